// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// Holds the mode encoding and the width-agnostic one-hot builder.
package seq_dec_pkg;

    typedef enum logic [1:0] {
        DECODE    = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        HOLD      = 2'b11
    } mode_e;

    localparam int MAX_OUT = 256;

    // Returns a one-hot vector at the widest legal size; callers truncate to N_OUT.
    // An index at or beyond n yields all-zero, so no caller can produce multi-hot.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [8:0] idx, input int unsigned n);
        logic [MAX_OUT-1:0] r;
        r = '0;
        if ({23'd0, idx} < n) begin
            r[idx[7:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_onehot_decoder_tick_div.sv
// Free-running modulo-DIV counter with synchronous clear and freeze.
// tick marks the terminal count and is suppressed on clear or freeze cycles.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic freeze,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (!freeze) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = (cnt_reg == LAST) & ~clr & ~freeze;

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered SEL_W-to-N_OUT one-hot decoder with valid/ready handshake
// and an autonomous up/down scan mode stepping at a divided rate.
module seq_onehot_decoder
    import seq_dec_pkg::*;
#(
    parameter int SEL_W    = 4,
    parameter int N_OUT    = 16,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_en,
    output logic [N_OUT-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [SEL_W-1:0] idx,
    output logic             range_err
);

    localparam logic [SEL_W:0] N_LIM    = (SEL_W + 1)'(N_OUT);
    localparam logic [SEL_W:0] LAST_IDX = (SEL_W + 1)'(N_OUT - 1);

    mode_e            mode_cur;
    mode_e            mode_reg;
    logic             mode_chg;
    logic             is_scan;
    logic             tick;
    logic             adv;
    logic             accept;
    logic             step;
    logic [SEL_W:0]   idx_ext;
    logic [SEL_W:0]   sel_ext;
    logic [SEL_W:0]   scan_idx;

    logic [N_OUT-1:0] y_reg, y_next;
    logic             y_valid_reg, y_valid_next;
    logic [SEL_W-1:0] idx_reg, idx_next;
    logic             range_err_reg, range_err_next;

    assign mode_cur = mode_e'(mode);
    assign mode_chg = (mode_cur != mode_reg);
    assign is_scan  = (mode_cur == SCAN_UP) || (mode_cur == SCAN_DOWN);

    tick_div #(
        .DIV (SCAN_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (mode_chg),
        .freeze (mode_cur == HOLD),
        .tick   (tick)
    );

    assign adv      = ~y_valid_reg | y_ready;
    assign in_ready = ~rst & (mode_cur == DECODE) & adv;
    assign accept   = in_valid & in_ready;
    assign step     = is_scan & tick & adv;

    assign idx_ext = {1'b0, idx_reg};
    assign sel_ext = {1'b0, in_sel};

    // Out-of-range indices left by a DECODE error re-enter the scan at the edge.
    always_comb begin
        scan_idx = '0;
        if (mode_cur == SCAN_UP) begin
            scan_idx = (idx_ext >= LAST_IDX) ? '0 : idx_ext + 1'b1;
        end else begin
            scan_idx = ((idx_ext == '0) || (idx_ext >= N_LIM)) ? LAST_IDX : idx_ext - 1'b1;
        end
    end

    always_comb begin
        y_next         = y_reg;
        y_valid_next   = y_valid_reg;
        idx_next       = idx_reg;
        range_err_next = range_err_reg;
        if (accept) begin
            y_next         = in_en ? N_OUT'(onehot(9'(sel_ext), N_OUT)) : '0;
            y_valid_next   = 1'b1;
            idx_next       = in_sel;
            range_err_next = (sel_ext >= N_LIM);
        end else if (step) begin
            y_next         = N_OUT'(onehot(9'(scan_idx), N_OUT));
            y_valid_next   = 1'b1;
            idx_next       = scan_idx[SEL_W-1:0];
            range_err_next = 1'b0;
        end else if (y_valid_reg && y_ready) begin
            y_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg      <= DECODE;
            y_reg         <= '0;
            y_valid_reg   <= 1'b0;
            idx_reg       <= '0;
            range_err_reg <= 1'b0;
        end else begin
            mode_reg      <= mode_cur;
            y_reg         <= y_next;
            y_valid_reg   <= y_valid_next;
            idx_reg       <= idx_next;
            range_err_reg <= range_err_next;
        end
    end

    assign y         = y_reg;
    assign y_valid   = y_valid_reg;
    assign idx       = idx_reg;
    assign range_err = range_err_reg;

endmodule
